// File: rtl/life_cursor_ctrl.sv
// Setup-side controller for the Game-of-Life grid: key conditioning, wrapped cursor, toggle pulse,
// generation tick and cursor blink. Define LIFE_CURSOR_AUTO_REPEAT_EN to auto-repeat held direction keys.
module life_cursor_ctrl #(
    parameter int ROWS         = 8,
    parameter int COLS         = 8,
    parameter int TICK_DIV     = 50_000_000,
    parameter int BLINK_DIV    = 12_500_000,
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 5_000_000
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      setup,
    input  logic                      key_up,
    input  logic                      key_down,
    input  logic                      key_left,
    input  logic                      key_right,
    input  logic                      key_toggle,
    output logic [ROWS-1:0]           row_sel,
    output logic [COLS-1:0]           col_sel,
    output logic [$clog2(ROWS)-1:0]   cur_row,
    output logic [$clog2(COLS)-1:0]   cur_col,
    output logic                      toggle,
    output logic                      gen_tick,
    output logic                      blink
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int TW = $clog2(TICK_DIV);
    localparam int BW = $clog2(BLINK_DIV);

    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    localparam int K_UP    = 0;
    localparam int K_DOWN  = 1;
    localparam int K_LEFT  = 2;
    localparam int K_RIGHT = 3;
    localparam int K_TOG   = 4;

    if (ROWS < 2 || COLS < 2 || TICK_DIV < 2 || BLINK_DIV < 2 ||
        REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
        $error("life_cursor_ctrl: parameter out of range");
    end

    function automatic logic [RW-1:0] step_row(input logic [RW-1:0] r,
                                               input logic inc, input logic dec);
        logic [RW-1:0] nxt;
        nxt = r;
        if (inc && !dec)
            nxt = (r == ROW_LAST) ? '0 : r + RW'(1);
        else if (dec && !inc)
            nxt = (r == '0) ? ROW_LAST : r - RW'(1);
        return nxt;
    endfunction

    function automatic logic [CW-1:0] step_col(input logic [CW-1:0] c,
                                               input logic inc, input logic dec);
        logic [CW-1:0] nxt;
        nxt = c;
        if (inc && !dec)
            nxt = (c == COL_LAST) ? '0 : c + CW'(1);
        else if (dec && !inc)
            nxt = (c == '0) ? COL_LAST : c - CW'(1);
        return nxt;
    endfunction

    // Stage p0/p1: two-flop synchronizer; p2: edge history. All preset to 1 so keys held
    // through reset never look like a fresh press.
    logic [4:0] key_p0, key_p1, key_p2;
    logic [4:0] rise;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            key_p0 <= '1;
            key_p1 <= '1;
            key_p2 <= '1;
        end else begin
            key_p0 <= {key_toggle, key_right, key_left, key_down, key_up};
            key_p1 <= key_p0;
            key_p2 <= key_p1;
        end
    end

    assign rise = key_p1 & ~key_p2;

    logic [3:0] mv;

`ifdef LIFE_CURSOR_AUTO_REPEAT_EN
    localparam int HMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int HW   = $clog2(HMAX) + 1;

    logic [HW-1:0] hold_cnt;
    logic          hold_rpt;
    logic [3:0]    dir_rep;
    logic          rep_fire;

    always_comb begin
        dir_rep = key_p1[3:0];
        if (dir_rep[K_UP] && dir_rep[K_DOWN]) begin
            dir_rep[K_UP]   = 1'b0;
            dir_rep[K_DOWN] = 1'b0;
        end
        if (dir_rep[K_LEFT] && dir_rep[K_RIGHT]) begin
            dir_rep[K_LEFT]  = 1'b0;
            dir_rep[K_RIGHT] = 1'b0;
        end
        rep_fire = (|dir_rep) &&
                   (hold_rpt ? (hold_cnt == HW'(REPEAT_RATE - 1))
                             : (hold_cnt == HW'(REPEAT_DELAY - 1)));
    end

    // One shared hold counter; any change in the held direction set restarts the delay.
    always_ff @(posedge Clock) begin
        if (Reset || !setup || (key_p1[3:0] != key_p2[3:0])) begin
            hold_cnt <= '0;
            hold_rpt <= 1'b0;
        end else if (rep_fire) begin
            hold_cnt <= '0;
            hold_rpt <= 1'b1;
        end else if (|dir_rep) begin
            hold_cnt <= hold_cnt + HW'(1);
        end
    end

    assign mv = rise[3:0] | (rep_fire ? dir_rep : 4'b0000);
`else
    assign mv = rise[3:0];
`endif

    // A move arriving with a toggle waits one cycle so the pulse hits the pre-move cell.
    logic [3:0] pend;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            cur_row <= '0;
            cur_col <= '0;
            toggle  <= 1'b0;
            pend    <= '0;
        end else if (!setup) begin
            toggle <= 1'b0;
            pend   <= '0;
        end else if (rise[K_TOG]) begin
            toggle <= 1'b1;
            pend   <= mv;
        end else begin
            toggle  <= 1'b0;
            pend    <= '0;
            cur_row <= step_row(step_row(cur_row, pend[K_DOWN], pend[K_UP]),
                                mv[K_DOWN], mv[K_UP]);
            cur_col <= step_col(step_col(cur_col, pend[K_RIGHT], pend[K_LEFT]),
                                mv[K_RIGHT], mv[K_LEFT]);
        end
    end

    always_comb begin
        row_sel          = '0;
        row_sel[cur_row] = 1'b1;
        col_sel          = '0;
        col_sel[cur_col] = 1'b1;
    end

    logic [TW-1:0] tick_cnt;

    always_ff @(posedge Clock) begin
        if (Reset || setup)
            tick_cnt <= '0;
        else if (tick_cnt == TICK_LAST)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + TW'(1);
    end

    assign gen_tick = (tick_cnt == TICK_LAST);

    // blink_act marks that setup mode has been entered; the first setup edge forces blink high.
    logic [BW-1:0] blink_cnt;
    logic          blink_act;

    always_ff @(posedge Clock) begin
        if (Reset || !setup) begin
            blink_cnt <= '0;
            blink_act <= 1'b0;
            blink     <= 1'b0;
        end else if (!blink_act) begin
            blink_cnt <= '0;
            blink_act <= 1'b1;
            blink     <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink     <= ~blink;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

endmodule

// File: tb/tb_life_cursor_ctrl.sv
// Directed bench for life_cursor_ctrl: key latency, wrap, coincident keys, toggle/pending, tick, blink, reset.
module tb_life_cursor_ctrl;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       setup = 1'b0;
    logic [4:0] keys  = 5'b00000;   // {toggle, right, left, down, up}
    logic [7:0] row_sel, col_sel;
    logic [2:0] cur_row, cur_col;
    logic       toggle, gen_tick, blink;

    int checks   = 0;
    int failures = 0;

    always #5 Clock = ~Clock;

    life_cursor_ctrl #(
        .ROWS(8), .COLS(8), .TICK_DIV(4), .BLINK_DIV(3),
        .REPEAT_DELAY(10), .REPEAT_RATE(4)
    ) dut (
        .Clock(Clock), .Reset(Reset), .setup(setup),
        .key_up(keys[0]), .key_down(keys[1]), .key_left(keys[2]),
        .key_right(keys[3]), .key_toggle(keys[4]),
        .row_sel(row_sel), .col_sel(col_sel),
        .cur_row(cur_row), .cur_col(cur_col),
        .toggle(toggle), .gen_tick(gen_tick), .blink(blink)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic       s;
        logic [4:0] k;
        int         row;
        int         col;
        int         togs;
    } vec_t;

    vec_t tbl[18];

    // Hold keys for two clock edges, release, then let the action settle; counts toggle pulses seen.
    task automatic press(input logic s, input logic [4:0] k, output int togs);
        togs  = 0;
        setup = s;
        keys  = k;
        repeat (2) begin
            @(negedge Clock);
            togs += int'(toggle);
        end
        keys = 5'b00000;
        repeat (4) begin
            @(negedge Clock);
            togs += int'(toggle);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         t;
        logic [7:0] exp_sel;

        tbl[0]  = '{1'b1, 5'b00010, 2, 0, 0};
        tbl[1]  = '{1'b1, 5'b00010, 3, 0, 0};
        tbl[2]  = '{1'b1, 5'b00010, 4, 0, 0};
        tbl[3]  = '{1'b1, 5'b00010, 5, 0, 0};
        tbl[4]  = '{1'b1, 5'b00011, 5, 0, 0};
        tbl[5]  = '{1'b1, 5'b00010, 6, 0, 0};
        tbl[6]  = '{1'b1, 5'b00010, 7, 0, 0};
        tbl[7]  = '{1'b1, 5'b00010, 0, 0, 0};
        tbl[8]  = '{1'b1, 5'b00100, 0, 7, 0};
        tbl[9]  = '{1'b1, 5'b01000, 0, 0, 0};
        tbl[10] = '{1'b1, 5'b00001, 7, 0, 0};
        tbl[11] = '{1'b1, 5'b01100, 7, 0, 0};
        tbl[12] = '{1'b1, 5'b01001, 6, 1, 0};
        tbl[13] = '{1'b0, 5'b00010, 6, 1, 0};
        tbl[14] = '{1'b0, 5'b10000, 6, 1, 0};
        tbl[15] = '{1'b1, 5'b10000, 6, 1, 1};
        tbl[16] = '{1'b1, 5'b11000, 6, 2, 1};
        tbl[17] = '{1'b1, 5'b00110, 7, 1, 0};

        // Reset with key_down held
        keys[1] = 1'b1;
        repeat (3) @(negedge Clock);
        check("reset_row", int'(cur_row), 0);
        check("reset_col", int'(cur_col), 0);
        check("reset_row_sel", int'(row_sel), 1);
        check("reset_toggle", int'(toggle), 0);
        check("reset_gen_tick", int'(gen_tick), 0);
        check("reset_blink", int'(blink), 0);

        Reset = 1'b0;
        setup = 1'b1;
        repeat (5) @(negedge Clock);
        check("held_through_reset_row", int'(cur_row), 0);
        keys = 5'b00000;
        repeat (4) @(negedge Clock);

        // Press latency: sampled high at edge 1, visible after edge 3
        keys[1] = 1'b1;
        @(negedge Clock);
        check("latency_edge1_row", int'(cur_row), 0);
        @(negedge Clock);
        check("latency_edge2_row", int'(cur_row), 0);
        @(negedge Clock);
        check("latency_edge3_row", int'(cur_row), 1);
        check("latency_edge3_row_sel", int'(row_sel), 8'b00000010);
        keys = 5'b00000;
        repeat (3) @(negedge Clock);

        for (int i = 0; i < 18; i++) begin
            press(tbl[i].s, tbl[i].k, t);
            check($sformatf("vec%0d_row", i), int'(cur_row), tbl[i].row);
            check($sformatf("vec%0d_col", i), int'(cur_col), tbl[i].col);
            exp_sel = 8'd1 << tbl[i].row;
            check($sformatf("vec%0d_row_sel", i), int'(row_sel), int'(exp_sel));
            exp_sel = 8'd1 << tbl[i].col;
            check($sformatf("vec%0d_col_sel", i), int'(col_sel), int'(exp_sel));
            check($sformatf("vec%0d_toggles", i), t, tbl[i].togs);
        end

        // Toggle and right together at (7,1): pulse on the old cell, move one cycle later
        keys = 5'b11000;
        @(negedge Clock);
        @(negedge Clock);
        keys = 5'b00000;
        @(negedge Clock);
        check("tog_move_toggle", int'(toggle), 1);
        check("tog_move_row_sel", int'(row_sel), 8'b10000000);
        check("tog_move_col_sel", int'(col_sel), 8'b00000010);
        check("tog_move_col_held", int'(cur_col), 1);
        @(negedge Clock);
        check("tog_move_toggle_off", int'(toggle), 0);
        check("tog_move_col_after", int'(cur_col), 2);
        repeat (3) @(negedge Clock);

        // Run mode: tick every 4th cycle counting the fall cycle, blink off
        setup = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge Clock);
            check($sformatf("gen_tick_k%0d", k), int'(gen_tick), int'(k % 4 == 3));
            check($sformatf("run_blink_k%0d", k), int'(blink), 0);
        end

        // Back to setup: blink starts high, 3 cycles per half-period, tick held off
        setup = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge Clock);
            check($sformatf("blink_k%0d", k), int'(blink), int'(((k - 1) / 3) % 2 == 0));
            check($sformatf("setup_gen_tick_k%0d", k), int'(gen_tick), 0);
        end
        check("mode_retain_row", int'(cur_row), 7);
        check("mode_retain_col", int'(cur_col), 2);

        // Reset while a move is pending behind a toggle pulse
        keys = 5'b10001;
        @(negedge Clock);
        @(negedge Clock);
        keys = 5'b00000;
        @(negedge Clock);
        check("midreset_toggle_pulse", int'(toggle), 1);
        check("midreset_row_before", int'(cur_row), 7);
        Reset = 1'b1;
        @(negedge Clock);
        check("midreset_row", int'(cur_row), 0);
        check("midreset_col", int'(cur_col), 0);
        check("midreset_toggle", int'(toggle), 0);
        check("midreset_blink", int'(blink), 0);
        Reset = 1'b0;
        repeat (4) @(negedge Clock);
        check("midreset_pending_dropped_row", int'(cur_row), 0);
        check("midreset_pending_dropped_col", int'(cur_col), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
